decode_3to8: RTL and testbench
==============================

// Module: decode_3to8
// PURPOSE
//   Registered 3-to-8 one-hot decoder. The 3-bit binary code din selects exactly
//   one of 8 output lines, and the result is registered one cycle after sampling.
//   Used as a select/enable generator for banked resources (register-file write
//   enables, chip selects). Downstream logic consumes dout directly.
// PARAMETERS
//   IN_W        3        width of binary select input; OUT_W = 2**IN_W
//   ACTIVE_LOW  0        0: selected line = 1, others 0; 1: selected line = 0, others 1
// PORTS
//   clk         input   1      rising-edge clock, single clock domain
//   rst         input   1      asynchronous active-high reset
//   en          input   1      decode enable, sampled on clk rising edge
//   din         input   IN_W   binary select code (0..7 at default)
//   dout        output  OUT_W  one-hot decoded lines (8 at default), registered
//   dout_valid  output  1      high while dout holds a decode of an enabled sample
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - Reset: while rst=1, dout = all-inactive immediately, without waiting for
//     a clock edge. All-inactive is 8'h00 (ACTIVE_LOW=0) or 8'hFF (ACTIVE_LOW=1).
//     dout_valid=0 during reset.
//   - First edge after reset: on the first rising clk edge with rst=0, sampling
//     resumes normally.
//   - Latency: exactly 1 cycle. At clk edge k with en=1:
//     dout[i] = active  iff  i == din  (else inactive); dout_valid = 1,
//     visible after edge k.
//   - en=0 at an edge: dout returns to all-inactive and dout_valid=0 at that edge.
//     en=0 does not hold the previous code.
//   - Every valid output is strictly one-hot (or one-cold for ACTIVE_LOW):
//     exactly one line active. Zero or multiple active lines never occur.
//   - din is fully decoded, with no don't-care codes. din=0 selects dout[0];
//     din=7 (max) selects dout[OUT_W-1]. Bit order is LSB = code 0.
//   - X/Z on din while en=1: no requirement on dout value. Implementation need
//     not propagate X.
//   - Reset asserted mid-operation overrides everything: outputs go inactive
//     asynchronously and remain inactive until the first edge after release.
//   - Back-to-back samples: a new din each cycle yields a new one-hot code each
//     cycle, with no bubbles.
//   - Pure combinational decode feeds the registers. No internal state other
//     than the output flops.
// TESTING
//   1. rst=1 asserted between clock edges -> dout=8'h00, dout_valid=0 before the
//      next edge. Release rst; the first edge with en=0 keeps dout=8'h00.
//   2. en=1, sweep din=0..7, one value per cycle -> dout after each edge is
//      01,02,04,08,10,20,40,80 (hex), and dout_valid=1 throughout.
//   3. din=5, en=1, then en=0 for one cycle -> dout=8'h20, then 8'h00 with
//      dout_valid=0. Re-enable with din=2 -> dout=8'h04.
//   4. din=7 steady, assert rst mid-cycle -> dout drops to 8'h00 asynchronously.
//      After release with en=1 -> dout=8'h80 one edge later.
//   5. ACTIVE_LOW=1, sweep din=0..7 -> dout = FE,FD,FB,F7,EF,DF,BF,7F.
//      Reset value is 8'hFF.
//   6. Random din/en for 1000 cycles -> each cycle, dout equals the model
//      (1<<din_prev when en_prev, else 0), and $countones(dout) is 1 or 0.

Source files
------------

// File: rtl/decode_3to8_if.sv
// Select/decode bus between a code source and the registered 3-to-8 decoder.
// The master drives enable and code; the slave returns the decoded lines.
interface decode_3to8_if #(
    parameter int unsigned IN_W = 3
) ();
    localparam int unsigned OUT_W = 2 ** IN_W;

    logic             en;
    logic [IN_W-1:0]  din;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;

    modport master (
        output en,
        output din,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  en,
        input  din,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/decode_3to8.sv
// Registered binary-to-one-hot decoder used as a bank select / write-enable generator.
// One cycle of latency; en=0 clears the lines rather than holding the last code.
module decode_3to8 #(
    parameter int unsigned IN_W       = 3,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    decode_3to8_if.slave  bus_io
);
    localparam int unsigned OUT_W = 2 ** IN_W;
    localparam logic [OUT_W-1:0] Inactive = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [OUT_W-1:0] sel;
    logic [OUT_W-1:0] dout_d, dout_q;
    logic             valid_d, valid_q;

    // Compare-per-line keeps every code fully decoded; at most one line can match.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            sel[i] = bus_io.en && (bus_io.din == IN_W'(i));
        end
    end

    always_comb begin
        dout_d  = ACTIVE_LOW ? ~sel : sel;
        valid_d = bus_io.en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= Inactive;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign bus_io.dout       = dout_q;
    assign bus_io.dout_valid = valid_q;
endmodule

// File: tb/tb_decode_3to8.sv
// Bench for decode_3to8: active-high and active-low instances share one stimulus stream,
// with expected results queued at drive time and compared one edge later.
module tb_decode_3to8;
    logic clk;
    logic rst;

    decode_3to8_if #(.IN_W(3)) bus_h ();
    decode_3to8_if #(.IN_W(3)) bus_l ();

    decode_3to8 #(.IN_W(3), .ACTIVE_LOW(1'b0)) u_dut_h (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_h)
    );

    decode_3to8 #(.IN_W(3), .ACTIVE_LOW(1'b1)) u_dut_l (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_l)
    );

    typedef struct packed {
        logic       v;
        logic [7:0] h;
        logic [7:0] l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic e, input logic [2:0] d);
        exp_t r;
        logic [7:0] one;
        one = 8'h01;
        r.v = e;
        r.h = e ? (one << d) : 8'h00;
        r.l = ~r.h;
        return r;
    endfunction

    task automatic drive(input logic e, input logic [2:0] d);
        bus_h.en  = e;
        bus_h.din = d;
        bus_l.en  = e;
        bus_l.din = d;
    endtask

    // Drive one sample, let one edge pass, then compare against the queued expectation.
    task automatic step(input string tag, input logic e, input logic [2:0] d);
        exp_t x;
        drive(e, d);
        sb.push_back(model(e, d));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            chk({tag, "_dout_h"}, {24'd0, bus_h.dout}, {24'd0, x.h});
            chk({tag, "_dout_l"}, {24'd0, bus_l.dout}, {24'd0, x.l});
            chk({tag, "_valid_h"}, {31'd0, bus_h.dout_valid}, {31'd0, x.v});
            chk({tag, "_valid_l"}, {31'd0, bus_l.dout_valid}, {31'd0, x.v});
            chk({tag, "_ones_h"}, $countones(bus_h.dout), x.v ? 32'd1 : 32'd0);
        end
    endtask

    task automatic chk_inactive(input string tag);
        chk({tag, "_dout_h"}, {24'd0, bus_h.dout}, 32'h00);
        chk({tag, "_dout_l"}, {24'd0, bus_l.dout}, 32'hFF);
        chk({tag, "_valid_h"}, {31'd0, bus_h.dout_valid}, 32'd0);
        chk({tag, "_valid_l"}, {31'd0, bus_l.dout_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_inactive("por");
        rst = 1'b0;

        // Test 1: async reset between edges, then first edge with en=0 stays inactive.
        step("pre1", 1'b1, 3'd3);
        rst = 1'b1;
        #1;
        chk_inactive("async_rst");
        sb.delete();
        #1;
        rst = 1'b0;
        step("rel_en0", 1'b0, 3'd3);

        // Test 2 and 5: full sweep, both polarities.
        for (int i = 0; i < 8; i++) step("sweep", 1'b1, 3'(i));

        // Test 3: enable drop clears the lines, re-enable picks up the new code.
        step("t3_d5", 1'b1, 3'd5);
        step("t3_off", 1'b0, 3'd5);
        step("t3_d2", 1'b1, 3'd2);

        // Test 4: reset mid-cycle with din=7, held across an edge, then released.
        step("t4_d7", 1'b1, 3'd7);
        rst = 1'b1;
        #1;
        chk_inactive("t4_async");
        sb.delete();
        @(posedge clk);
        #1;
        chk_inactive("t4_held");
        rst = 1'b0;
        step("t4_rel", 1'b1, 3'd7);

        // Test 6: random traffic.
        for (int i = 0; i < 1000; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
